// File: rtl/text_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : text_dump_tx
//  Description : Reads the character RAM in on-screen order and sends it out
//                as UART 8N1. Each row ends with CR LF. Non-printable bytes
//                are sent as spaces.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_dump_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ROWS         = 4,
  parameter int COLS         = 32,
  parameter int START_COL    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [$clog2(ROWS)-1:0] rd_row,
  output logic [$clog2(COLS)-1:0] rd_col,
  input  logic [7:0]              rd_data,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(START_COL);
  localparam logic [COL_W-1:0]  COL_WRAP  = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  // Last column visited in a row is the one just before the first visible one.
  localparam logic [COL_W-1:0]  COL_LAST  = (START_COL == 0) ? COL_W'(COLS - 1)
                                                             : COL_W'(START_COL - 1);
  // Bit index 0 is the start bit, 1..8 data, 9 the stop bit.
  localparam logic [3:0]        STOP_IDX  = 4'd9;
  localparam logic [3:0]        BIT_ONE   = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_CR    = 3'd5,
    S_LF    = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [8:0]        shreg_q;     // remaining bits after the one on tx: {stop, data}
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic              sending_q;
  logic              tx_q;

  logic              frame_end;
  logic              load_frame;
  logic [7:0]        frame_byte;
  logic              printable;

  assign printable = (rd_data >= 8'h20) && (rd_data < 8'h7F);
  assign frame_end = sending_q && (baud_q == BAUD_LAST) && (bit_q == STOP_IDX);

  // Pick the byte for the next frame and decide when a frame is launched.
  always_comb begin
    load_frame = 1'b0;
    frame_byte = 8'h20;
    case (state_q)
      S_LOAD: begin
        load_frame = 1'b1;
        frame_byte = printable ? rd_data : 8'h20;
      end
      S_CR: begin
        load_frame = !sending_q;
        frame_byte = 8'h0D;
      end
      S_LF: begin
        load_frame = !sending_q;
        frame_byte = 8'h0A;
      end
      default: begin
        load_frame = 1'b0;
        frame_byte = 8'h20;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk cells, then CR and LF at the end of every row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (frame_end) state_d = (col_q == COL_LAST) ? S_CR : S_ADDR;
      S_CR:    if (frame_end) state_d = S_LF;
      S_LF:    if (frame_end) state_d = (row_q == ROW_LAST) ? S_DONE : S_ADDR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // UART serializer: each frame restarts the baud counter, so there is no drift.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= 9'h1FF;
      baud_q    <= '0;
      bit_q     <= '0;
      sending_q <= 1'b0;
      tx_q      <= 1'b1;
    end else if (load_frame) begin
      shreg_q   <= {1'b1, frame_byte};
      baud_q    <= '0;
      bit_q     <= '0;
      sending_q <= 1'b1;
      tx_q      <= 1'b0;
    end else if (sending_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_q <= '0;
        if (bit_q == STOP_IDX) begin
          sending_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + BIT_ONE;
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b1, shreg_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + BAUD_ONE;
      end
    end
  end

  // Read-address walker: columns wrap past COLS-1, rows advance after LF.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= COL_FIRST;
    end else if (state_q == S_DONE) begin
      row_q <= '0;
      col_q <= COL_FIRST;
    end else if ((state_q == S_SEND) && frame_end && (col_q != COL_LAST)) begin
      col_q <= (col_q == COL_WRAP) ? '0 : col_q + COL_ONE;
    end else if ((state_q == S_LF) && frame_end && (row_q != ROW_LAST)) begin
      row_q <= row_q + ROW_ONE;
      col_q <= COL_FIRST;
    end
  end

  assign rd_row = row_q;
  assign rd_col = col_q;
  assign tx     = tx_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_text_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_dump_tx
//  Description : Self-checking bench for text_dump_tx with a behavioural RAM,
//                a frame-decoding monitor and an expected-byte queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_dump_tx;

  localparam int CPB       = 4;
  localparam int ROWS      = 4;
  localparam int COLS      = 32;
  localparam int START_COL = 24;
  localparam int FRAME_LEN = 10 * CPB;
  localparam int NFRAMES   = ROWS * (COLS + 2);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .START_COL   (START_COL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  // Character RAM with one-cycle synchronous read.
  logic [7:0] ram [ROWS][COLS];
  always @(posedge clk) rd_data <= ram[rd_row][rd_col];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: the byte stream a host terminal should receive.
  logic [7:0] exp_q[$];

  function automatic logic [7:0] shown(input logic [7:0] b);
    return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < COLS; k++) begin
        int c;
        c = (START_COL + k) % COLS;
        exp_q.push_back(shown(ram[r][c]));
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic randomize_ram();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ram[r][c] = 8'($urandom_range(0, 255));
  endtask

  // Monitor state.
  bit         capturing = 1'b0;
  int         cap_n = 0;
  logic       samp [FRAME_LEN];
  int         gap_cnt = 0;
  bit         prev_frame = 1'b0;
  logic       prev_busy = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_log [256];
  int         done_cnt = 0;
  logic [7:0] mon_byte;
  bit         mon_ok;

  // Compare process: idle outputs, done/busy relation, and every UART frame.
  always @(negedge clk) begin
    if (reset) begin
      capturing  = 1'b0;
      cap_n      = 0;
      prev_frame = 1'b0;
      gap_cnt    = 0;
    end else begin
      if (!busy && !done) begin
        chk("idle_tx", 32'(tx), 1);
        chk("idle_rd_row", 32'(rd_row), 0);
        chk("idle_rd_col", 32'(rd_col), START_COL);
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", 32'(busy), 0);
        chk("busy_before_done", 32'(prev_busy), 1);
        chk("done_all_frames_sent", exp_q.size(), 0);
        prev_frame = 1'b0;
      end
      if (!capturing) begin
        if (tx === 1'b0) begin
          if (prev_frame) begin
            checks++;
            if (gap_cnt < 1 || gap_cnt > 4) begin
              errors++;
              $display("FAIL inter_frame_gap: got %0d idle cycles, required 1..4", gap_cnt);
            end
          end
          capturing = 1'b1;
          samp[0]   = tx;
          cap_n     = 1;
        end else begin
          gap_cnt++;
        end
      end else begin
        samp[cap_n] = tx;
        cap_n++;
        if (cap_n == FRAME_LEN) begin
          capturing = 1'b0;
          mon_ok    = 1'b1;
          for (int i = 0; i < 10; i++)
            for (int k = 1; k < CPB; k++)
              if (samp[i*CPB+k] !== samp[i*CPB]) mon_ok = 1'b0;
          if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) mon_ok = 1'b0;
          for (int b = 0; b < 8; b++) mon_byte[b] = samp[(b+1)*CPB];
          chk("frame_bit_timing", 32'(mon_ok), 1);
          chk("frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          if (rx_n < 256) rx_log[rx_n] = mon_byte;
          rx_n++;
          prev_frame = 1'b1;
          gap_cnt    = 0;
        end
      end
    end
    prev_busy = busy;
  end

  // One full dump; optionally re-pulse start at cycle mid_start_at of the dump.
  task automatic run_dump(input int mid_start_at);
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    rx_n = 0;
    build_expected();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("first_addr_row", 32'(rd_row), 0);
    chk("first_addr_col", 32'(rd_col), START_COL);
    while (done_cnt == d0 && t < 12000) begin
      start = (t == mid_start_at);
      tick(1);
      t++;
    end
    start = 1'b0;
    chk("dump_done_seen", done_cnt - d0, 1);
    tick(300);
    chk("dump_frame_count", rx_n, NFRAMES);
    chk("dump_single_done", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int n0;
    int t;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ram[r][c] = 8'h20;

    // Reset values.
    reset = 1'b1;
    tick(5);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rd_row", 32'(rd_row), 0);
    chk("reset_rd_col", 32'(rd_col), 24);
    reset = 1'b0;
    tick(1000);
    chk("quiet_tx", 32'(tx), 1);
    chk("quiet_frames", rx_n, 0);

    // Dump with hand-placed characters and a mid-dump start.
    randomize_ram();
    ram[0][24] = 8'h41;
    ram[0][25] = 8'h42;
    ram[1][24] = 8'h00;
    ram[1][25] = 8'h7F;
    ram[1][26] = 8'h7E;
    build_expected();
    chk("model_size", exp_q.size(), 136);
    chk("model_first", 32'(exp_q[0]), 32'h41);
    chk("model_row0_lf", 32'(exp_q[33]), 32'h0A);
    chk("model_ctrl_00", 32'(exp_q[34]), 32'h20);
    chk("model_ctrl_7f", 32'(exp_q[35]), 32'h20);
    run_dump(700);
    chk("rx_first_A", 32'(rx_log[0]), 32'h41);
    chk("rx_second_B", 32'(rx_log[1]), 32'h42);
    chk("rx_row0_cr", 32'(rx_log[32]), 32'h0D);
    chk("rx_row0_lf", 32'(rx_log[33]), 32'h0A);
    chk("rx_row1_nul", 32'(rx_log[34]), 32'h20);
    chk("rx_row1_del", 32'(rx_log[35]), 32'h20);
    chk("rx_row1_tilde", 32'(rx_log[36]), 32'h7E);
    chk("rx_last_lf", 32'(rx_log[135]), 32'h0A);

    // Fully random contents.
    randomize_ram();
    run_dump(-1);

    // Reset during data bits of the first row-2 frame.
    randomize_ram();
    rx_n = 0;
    build_expected();
    d0 = done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t = 0;
    while (!(rx_n >= 68 && capturing && cap_n >= 8 && cap_n <= 30) && t < 8000) begin
      tick(1);
      t++;
    end
    chk("reach_row2_frame", 32'(t < 8000), 1);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    chk("abort_tx_high", 32'(tx), 1);
    chk("abort_busy_low", 32'(busy), 0);
    chk("abort_done_low", 32'(done), 0);
    tick(200);
    chk("abort_no_done", done_cnt - d0, 0);
    randomize_ram();
    run_dump(-1);

    // start and reset together: reset wins.
    d0 = done_cnt;
    n0 = rx_n;
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    chk("start_reset_busy", 32'(busy), 0);
    chk("start_reset_tx", 32'(tx), 1);
    tick(100);
    chk("start_reset_still_idle", 32'(busy), 0);
    chk("start_reset_no_frames", rx_n - n0, 0);
    chk("start_reset_no_done", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
